// File: rtl/seven_segment_scanner.sv
// Multiplexed 7-segment driver: clock-enable scanning, per-frame input snapshot,
// PWM brightness, per-digit blink, leading-zero blanking and selectable output polarity.
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 6,
  parameter int DIGIT_TICKS    = 814,
  parameter int BRIGHT_BITS    = 3,
  parameter int BLINK_FRAMES   = 40,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [NUM_DIGITS-1:0]   dp_enable,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank_en,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PW = BRIGHT_BITS + TW + 1;
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};

  logic [TW-1:0]           tick;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic                    boundary, tick_last, idx_last;

  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_en, snap_dp, snap_blink;
  logic                    snap_lz, snap_phase;
  logic [TW-1:0]           snap_on;

  logic [4*NUM_DIGITS-1:0] data_eff;
  logic [NUM_DIGITS-1:0]   en_eff, dp_eff, blink_eff, blank;
  logic                    lz_eff, phase_eff, lit, run;
  logic [TW-1:0]           on_live, on_eff;
  logic [PW-1:0]           prod;
  logic [3:0]              nibble;
  logic [7:0]              font, seg_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  assign boundary  = (idx == '0) && (tick == '0);
  assign tick_last = (tick == TW'(DIGIT_TICKS - 1));
  assign idx_last  = (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick        <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (tick_last) begin
        tick <= '0;
        idx  <= idx_last ? '0 : idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
      if (boundary) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // The frame's blink phase is captured before the boundary toggle, so a
  // toggle takes effect from the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_data  <= '0;
      snap_en    <= '0;
      snap_dp    <= '0;
      snap_blink <= '0;
      snap_lz    <= 1'b0;
      snap_phase <= 1'b0;
      snap_on    <= '0;
    end else if (boundary) begin
      snap_data  <= data;
      snap_en    <= digit_enable;
      snap_dp    <= dp_enable;
      snap_blink <= blink_mask;
      snap_lz    <= lz_blank_en;
      snap_phase <= blink_phase;
      snap_on    <= on_live;
    end
  end

  assign prod    = PW'(brightness) * PW'(DIGIT_TICKS);
  assign on_live = TW'(prod >> BRIGHT_BITS);

  // Position (0,0) is decoded in the cycle the snapshot loads, so bypass to live inputs.
  always_comb begin
    data_eff  = boundary ? data         : snap_data;
    en_eff    = boundary ? digit_enable : snap_en;
    dp_eff    = boundary ? dp_enable    : snap_dp;
    blink_eff = boundary ? blink_mask   : snap_blink;
    lz_eff    = boundary ? lz_blank_en  : snap_lz;
    phase_eff = boundary ? blink_phase  : snap_phase;
    on_eff    = boundary ? on_live      : snap_on;
  end

  always_comb begin
    blank = '0;
    run   = lz_eff;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      int unsigned i;
      i   = NUM_DIGITS - 1 - k;
      run = run && (data_eff[4*i +: 4] == 4'h0) && !dp_eff[i];
      if (i != 0) blank[i] = run;
    end
  end

  always_comb begin
    nibble = data_eff[{idx, 2'b00} +: 4];
    case (nibble)
      4'h0: font = 8'hFC;
      4'h1: font = 8'h60;
      4'h2: font = 8'hDA;
      4'h3: font = 8'hF2;
      4'h4: font = 8'h66;
      4'h5: font = 8'hB6;
      4'h6: font = 8'hBE;
      4'h7: font = 8'hE0;
      4'h8: font = 8'hFE;
      4'h9: font = 8'hF6;
      4'hA: font = 8'hEE;
      4'hB: font = 8'h3E;
      4'hC: font = 8'h9C;
      4'hD: font = 8'h7A;
      4'hE: font = 8'h9E;
      default: font = 8'h8E;
    endcase
    lit = en_eff[idx] && (tick < on_eff) && !(phase_eff && blink_eff[idx]) && !blank[idx];
    seg_nxt = lit ? (font | {7'b0, dp_eff[idx]}) : '0;
    sel_nxt = lit ? (NUM_DIGITS'(1) << idx) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_out     <= SEG_OFF;
      digit_sel   <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_nxt ^ SEG_OFF;
      digit_sel   <= sel_nxt ^ DIG_OFF;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Frame-by-frame directed check of seven_segment_scanner (4 digits, 4 ticks/slot),
// plus an active-low instance used for the asynchronous mid-frame reset case.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [15:0] data;
  logic [3:0]  digit_enable, dp_enable, blink_mask;
  logic        lz_blank_en;
  logic [1:0]  brightness;
  logic [7:0]  seg_out, seg2;
  logic [3:0]  digit_sel, sel2;
  logic        frame_start, fs2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS(4), .DIGIT_TICKS(4), .BRIGHT_BITS(2), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .reset_n(rst_n), .data(data), .digit_enable(digit_enable),
    .dp_enable(dp_enable), .blink_mask(blink_mask), .lz_blank_en(lz_blank_en),
    .brightness(brightness), .seg_out(seg_out), .digit_sel(digit_sel),
    .frame_start(frame_start)
  );

  seven_segment_scanner #(
    .NUM_DIGITS(4), .DIGIT_TICKS(4), .BRIGHT_BITS(2), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut_al (
    .clk(clk), .reset_n(rst2_n), .data(data), .digit_enable(digit_enable),
    .dp_enable(dp_enable), .blink_mask(blink_mask), .lz_blank_en(lz_blank_en),
    .brightness(brightness), .seg_out(seg2), .digit_sel(sel2),
    .frame_start(fs2)
  );

  // One record per frame; seg[d] is the expected lit pattern of digit d (0 = dark),
  // on is the lit cycles per slot, mid clears data once idx reaches 2.
  typedef struct {
    logic [15:0]     data;
    logic [3:0]      en;
    logic [3:0]      dp;
    logic [3:0]      blink;
    logic            lz;
    logic [1:0]      br;
    logic            mid;
    logic [3:0][7:0] seg;
    int              on;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    data         = v.data;
    digit_enable = v.en;
    dp_enable    = v.dp;
    blink_mask   = v.blink;
    lz_blank_en  = v.lz;
    brightness   = v.br;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // blink phase (mask bit set) is dark in frames 2,3,6,7,10,11
    vecs[0]  = '{16'h1A2F, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 3};
    vecs[1]  = '{16'h1A2F, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3, 1'b1, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 3};
    vecs[2]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0, {8'h00, 8'h00, 8'h00, 8'hFC}, 3};
    vecs[3]  = '{16'h0050, 4'hF, 4'h0, 4'h0, 1'b1, 2'd3, 1'b0, {8'h00, 8'h00, 8'hB6, 8'hFC}, 3};
    vecs[4]  = '{16'h0050, 4'hF, 4'h4, 4'h0, 1'b1, 2'd3, 1'b0, {8'h00, 8'hFD, 8'hB6, 8'hFC}, 3};
    vecs[5]  = '{16'h1A2F, 4'hF, 4'h0, 4'h1, 1'b0, 2'd3, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 3};
    vecs[6]  = '{16'h1A2F, 4'hF, 4'h0, 4'h1, 1'b0, 2'd3, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h00}, 3};
    vecs[7]  = '{16'h1A2F, 4'hF, 4'h0, 4'h1, 1'b0, 2'd3, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h00}, 3};
    vecs[8]  = '{16'h1A2F, 4'hF, 4'h0, 4'h1, 1'b0, 2'd3, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 3};
    vecs[9]  = '{16'h1A2F, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 0};
    vecs[10] = '{16'h1A2F, 4'hF, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 1};
    vecs[11] = '{16'h1A2F, 4'hA, 4'h0, 4'h0, 1'b0, 2'd2, 1'b0, {8'h60, 8'h00, 8'hDA, 8'h00}, 2};
    vecs[12] = '{16'h1A2F, 4'hF, 4'h0, 4'h4, 1'b0, 2'd3, 1'b0, {8'h60, 8'hEE, 8'hDA, 8'h8E}, 3};

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    apply(vecs[0]);
    @(negedge clk);
    check("reset seg",      {8'h0, seg_out},     16'h0000);
    check("reset sel",      {12'h0, digit_sel},  16'h0000);
    check("reset fs",       {15'h0, frame_start}, 16'h0000);
    check("reset al seg",   {8'h0, seg2},        16'h00FF);
    check("reset al sel",   {12'h0, sel2},       16'h000F);

    for (int f = 0; f < 13; f++) begin
      apply(vecs[f]);
      if (f == 0) begin
        rst_n  = 1'b1;
        rst2_n = 1'b1;
      end
      for (int p = 0; p < 16; p++) begin
        int         d, t;
        logic       lit;
        logic [7:0] eseg;
        logic [3:0] esel;
        cycle();
        d    = p / 4;
        t    = p % 4;
        lit  = (t < vecs[f].on) && (vecs[f].seg[d] != 8'h00);
        eseg = lit ? vecs[f].seg[d] : 8'h00;
        esel = lit ? (4'b0001 << d) : 4'b0000;
        check($sformatf("f%0d p%0d seg", f, p), {8'h0, seg_out},     {8'h0, eseg});
        check($sformatf("f%0d p%0d sel", f, p), {12'h0, digit_sel},  {12'h0, esel});
        check($sformatf("f%0d p%0d fs", f, p),  {15'h0, frame_start}, {15'h0, (p == 0)});
        if (vecs[f].mid && p == 8) data = 16'h0000;
      end
    end

    // Frame 13 with vecs[12] inputs on both instances; active-low instance checked here.
    repeat (7) cycle();
    check("al d1 lit seg",  {8'h0, seg2},  16'h0025);
    check("al d1 lit sel",  {12'h0, sel2}, 16'h000D);
    cycle();
    check("al dark seg",    {8'h0, seg2},  16'h00FF);
    check("al dark sel",    {12'h0, sel2}, 16'h000F);
    cycle();
    check("al d2 lit seg",  {8'h0, seg2},  16'h0011);
    check("al d2 lit sel",  {12'h0, sel2}, 16'h000B);
    rst2_n = 1'b0;
    #1;
    check("al async rst seg", {8'h0, seg2},  16'h00FF);
    check("al async rst sel", {12'h0, sel2}, 16'h000F);
    check("al async rst fs",  {15'h0, fs2},  16'h0000);
    check("other dut seg",    {8'h0, seg_out},    16'h00EE);
    check("other dut sel",    {12'h0, digit_sel}, 16'h0004);
    repeat (2) cycle();
    check("al held rst seg", {8'h0, seg2},  16'h00FF);
    check("al held rst fs",  {15'h0, fs2},  16'h0000);
    rst2_n = 1'b1;
    #1;
    check("al release fs",   {15'h0, fs2},  16'h0000);
    @(posedge clk);
    #1;
    check("al first fs",     {15'h0, fs2},  16'h0001);
    check("al first seg",    {8'h0, seg2},  16'h0071);
    check("al first sel",    {12'h0, sel2}, 16'h000E);
    @(posedge clk);
    #1;
    check("al second fs",    {15'h0, fs2},  16'h0000);
    check("al second seg",   {8'h0, seg2},  16'h0071);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised multiplexed driver for common-anode or common-cathode 7-segment LED banks. Displays a NUM_DIGITS-nibble hexadecimal value.
- Improvements over the first-generation driver:
  - clock-enable timing; no derived clock
  - whole-frame atomic snapshot of all inputs
  - PWM brightness per digit slot
  - per-digit blink
  - leading-zero blanking
  - configurable output polarity
- Sits between the register/status logic and the board LED pins.

Parameters:
- NUM_DIGITS, 6: digit count. Must be >= 2.
- DIGIT_TICKS, 814: clk cycles per digit slot. Must be >= 2. The default gives 80 Hz frame refresh at 390625 Hz with 6 digits. Set small for simulation.
- BRIGHT_BITS, 3: width of the brightness input.
- BLINK_FRAMES, 40: frames per blink half-period. Must be >= 1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_out.
- DIG_ACTIVE_LOW, 0: 1 inverts digit_sel.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- data  in  4*NUM_DIGITS  value to show. Nibble i is digit i; digit 0 is least significant.
- digit_enable  in  NUM_DIGITS  1 = digit may light
- dp_enable  in  NUM_DIGITS  1 = decimal point lit on that digit
- blink_mask  in  NUM_DIGITS  1 = digit blinks
- lz_blank_en  in  1  1 = suppress leading zeros
- brightness  in  BRIGHT_BITS  PWM duty code
- seg_out  out  8  segments. bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- digit_sel  out  NUM_DIGITS  one-hot-or-zero digit drive
- frame_start  out  1  one-cycle pulse aligned with the first output cycle of each frame

Reset is asynchronous, active-low on reset_n; the clock is clk.

Behaviour:
- Counters:
  - tick counts 0..DIGIT_TICKS-1.
  - idx counts 0..NUM_DIGITS-1 and advances when tick wraps; idx wraps to 0 after NUM_DIGITS-1.
  - The frame boundary is the cycle where idx=0 and tick=0.
- Snapshot:
  - At the end of the frame-boundary cycle, register data, digit_enable, dp_enable, blink_mask, lz_blank_en and brightness.
  - Also register on_cycles = (brightness*DIGIT_TICKS)>>BRIGHT_BITS, truncated.
  - Input changes mid-frame have no effect until the next boundary.
- Blink phase:
  - A frame counter toggles blink_phase at each boundary where it reaches BLINK_FRAMES-1, then returns to 0.
  - blink_phase resets to 0, which means visible.
- Digit lit (all conditions required):
  - digit_enable[idx] is set
  - tick < on_cycles
  - not (blink_phase and blink_mask[idx])
  - not blanked as a leading zero
- Leading-zero blanking, when lz_blank_en is set:
  - Digit i is blanked if nibbles i..NUM_DIGITS-1 are all zero and dp_enable bits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
- Font (hex): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
- Lit digit:
  - seg_out = font | dp_enable[idx] on bit0
  - digit_sel = one-hot at idx
- Unlit digit: seg_out=0 and digit_sel=0 (before polarity inversion).
- Pipeline:
  - seg_out, digit_sel and frame_start are registered.
  - The value for counter position (idx,tick) appears 1 cycle after the counters hold it, so the decode for position (0,0) uses the new snapshot.
- Reset (asynchronous, including mid-frame):
  - tick, idx, the frame counter and blink_phase clear; all snapshots clear.
  - seg_out and digit_sel go to inactive levels: all 0, or all 1 when the corresponding ACTIVE_LOW parameter is 1.
  - frame_start = 0.
  - First cycle after release: counters at (0,0), snapshot loads. Second cycle: frame_start=1 with digit 0 output.
- Brightness 0 means fully dark. The maximum code gives on_cycles = DIGIT_TICKS*(2^B-1)/2^B.
- At most one digit_sel bit is active in any cycle. No glitch at a slot change, because outputs are registered.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_TICKS=4, BRIGHT_BITS=2, BLINK_FRAMES=2 unless stated otherwise.

1. Basic scan: data=16'h1A2F, all enables set, dp_enable=0, brightness=3 -> per slot, 3 lit cycles then 1 dark.
   - Digit 0: seg=8E, sel=0001. Digit 1: seg=DA, sel=0010. Digit 2: seg=EE, sel=0100. Digit 3: seg=60, sel=1000.
   - frame_start pulses every 16 cycles.
2. Snapshot atomicity: change data to 16'h0000 while idx=2 -> digits 2 and 3 still show A and 1. The new value shows from the next frame_start.
3. Leading zeros: data=16'h0050, lz_blank_en=1 -> digits 3 and 2 have sel=0000. Then set dp_enable=4'b0100 -> digit 2 shows seg=FD.
4. Blink: blink_mask=4'b0001 -> digit 0 is dark in frames 2,3 and 6,7, lit in frames 0,1 and 4,5. Other digits are unaffected.
5. Brightness: brightness=0 -> sel stays 0000. brightness=1 -> exactly 1 lit cycle per slot.
6. Reset mid-frame with SEG_ACTIVE_LOW=1 and DIG_ACTIVE_LOW=1: assert reset_n=0 at idx=2 -> seg_out=FF and sel=1111 immediately. After release, frame_start occurs exactly 2 cycles later.
